// File: rtl/ram8_burst_ctrl_pkg.sv
// ram8 burst controller: shared widths and FSM encoding.
// Imported by the controller and its bench.
package ram8_ctrl_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/ram8_burst_ctrl_if.sv
// Host side of the burst controller: command,
// write stream, read stream and status.
interface ram8_burst_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [ADDR_W-1:0] cmd_len;

  logic [DATA_W-1:0] wr_data;
  logic              wr_valid;
  logic              wr_ready;

  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_ready;

  logic              busy;
  logic              done;

  modport master (
    output cmd_valid, cmd_write,
    output cmd_addr, cmd_len,
    output wr_data, wr_valid,
    output rd_ready,
    input  cmd_ready, wr_ready,
    input  rd_data, rd_valid,
    input  busy, done
  );

  modport slave (
    input  cmd_valid, cmd_write,
    input  cmd_addr, cmd_len,
    input  wr_data, wr_valid,
    input  rd_ready,
    output cmd_ready, wr_ready,
    output rd_data, rd_valid,
    output busy, done
  );

endinterface

// File: rtl/ram8_burst_ctrl.sv
// Single-direction burst initiator for one ram8;
// addresses wrap modulo the RAM depth.
module ram8_burst_ctrl #(
  parameter int DATA_W = ram8_ctrl_pkg::DATA_W,
  parameter int ADDR_W = ram8_ctrl_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  ram8_burst_ctrl_if.slave  host,
  output logic [DATA_W-1:0] mem_in,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_load,
  input  logic [DATA_W-1:0] mem_out
);

  import ram8_ctrl_pkg::*;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] rem_q, rem_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              done_q, done_d;
  logic              wr_hs;
  logic              fetch;

  assign wr_hs = (state_q == WRITE) && host.wr_valid;
  // Refill the output register when it is empty or being drained.
  assign fetch = (state_q == READ) &&
                 (!rd_valid_q || host.rd_ready);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      rem_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      rem_q      <= rem_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    rem_d      = rem_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_valid_q;
    done_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (host.cmd_valid) begin
          ptr_d   = host.cmd_addr;
          rem_d   = host.cmd_len;
          state_d = host.cmd_write ? WRITE : READ;
        end
      end
      WRITE: begin
        if (wr_hs) begin
          ptr_d = ptr_q + 1'b1;
          if (rem_q == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            rem_d = rem_q - 1'b1;
          end
        end
      end
      READ: begin
        if (fetch) begin
          rd_data_d  = mem_out;
          rd_valid_d = 1'b1;
          ptr_d      = ptr_q + 1'b1;
          if (rem_q == '0) state_d = DRAIN;
          else rem_d = rem_q - 1'b1;
        end
      end
      DRAIN: begin
        if (host.rd_ready) begin
          rd_valid_d = 1'b0;
          done_d     = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign host.cmd_ready = (state_q == IDLE);
  assign host.wr_ready  = (state_q == WRITE);
  assign host.rd_data   = rd_data_q;
  assign host.rd_valid  = rd_valid_q;
  assign host.busy      = (state_q != IDLE);
  assign host.done      = done_q;

  assign mem_address = ptr_q;
  assign mem_in      = host.wr_data;
  assign mem_load    = wr_hs;

endmodule

// File: tb/tb_ram8_burst_ctrl.sv
// Bench for ram8_burst_ctrl: table vectors, directed
// corner sequences and random bursts against a memory model.
module tb_ram8_burst_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ram8_burst_ctrl_if #(.DATA_W(16), .ADDR_W(3)) bus ();

  logic [15:0] mem_in;
  logic [15:0] mem_out;
  logic [2:0]  mem_address;
  logic        mem_load;

  ram8_burst_ctrl #(.DATA_W(16), .ADDR_W(3)) dut (
    .clk         (clk),
    .reset       (reset),
    .host        (bus),
    .mem_in      (mem_in),
    .mem_address (mem_address),
    .mem_load    (mem_load),
    .mem_out     (mem_out)
  );

  logic [15:0] ram [8];
  always @(posedge clk) if (mem_load) ram[mem_address] <= mem_in;
  assign mem_out = ram[mem_address];

  int loads = 0;
  always @(posedge clk) if (mem_load) loads++;

  int tests = 0;
  int fails = 0;
  logic [15:0] ref_mem [8];
  logic [15:0] wbuf [8];
  logic [15:0] rbuf [8];
  int last_cyc, busy_n;

  typedef struct {
    logic        wr;
    logic [2:0]  addr;
    logic [2:0]  len;
    int          p;
    logic [15:0] d [4];
  } vec_t;
  vec_t tbl [6];

  task automatic check(input string nm,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // 0: always, 1: toggle 1,0,.., 2: cycles 1,4,5,9, else random
  function automatic logic pat(input int p, input int c);
    case (p)
      0: return 1'b1;
      1: return c[0];
      2: return (c == 1 || c == 4 || c == 5 || c == 9);
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  task automatic run_burst(input logic wr, input logic [2:0] a,
                           input logic [2:0] l, input int p);
    int w, n, cyc;
    logic hold;
    logic [15:0] hdata;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = a;
    bus.cmd_len   = l;
    w = 0;
    #1;
    while (!bus.cmd_ready && w < 50) begin
      @(negedge clk); #1; w++;
    end
    check("cmd_accept_wait", 32'(w < 50), 32'd1);
    n = 0; cyc = 0; busy_n = 0; hold = 1'b0; hdata = '0;
    while (n <= int'(l) && cyc < 200) begin
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      cyc++;
      bus.wr_valid = wr & pat(p, cyc);
      bus.rd_ready = !wr & pat(p, cyc);
      bus.wr_data  = wbuf[n];
      #1;
      if (bus.busy) busy_n++;
      check("done_early", 32'(bus.done), 32'd0);
      if (wr) begin
        check("mem_load", 32'(mem_load), 32'(bus.wr_valid));
        if (bus.wr_valid && bus.wr_ready) n++;
      end else begin
        if (hold) check("rd_hold", 32'(bus.rd_data), 32'(hdata));
        if (bus.rd_valid && bus.rd_ready) begin
          rbuf[n] = bus.rd_data;
          n++;
        end
        hold  = bus.rd_valid && !bus.rd_ready;
        hdata = bus.rd_data;
      end
    end
    last_cyc = cyc;
    check("beat_count", 32'(n), 32'(int'(l) + 1));
    @(negedge clk);
    bus.wr_valid = 1'b0;
    bus.rd_ready = 1'b0;
    #1;
    check("done_pulse", 32'(bus.done), 32'd1);
    check("idle_after", 32'(bus.busy), 32'd0);
    check("rdv_after", 32'(bus.rd_valid), 32'd0);
  endtask

  initial begin
    int idx, l0;
    logic [15:0] w0, w1;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    bus.wr_data   = '0;
    bus.wr_valid  = 1'b0;
    bus.rd_ready  = 1'b0;

    tbl[0] = '{1'b1, 3'd2, 3'd3, 0,
               '{16'h1111, 16'h2222, 16'h3333, 16'h4444}};
    tbl[1] = '{1'b1, 3'd6, 3'd3, 0,
               '{16'hA0A0, 16'hB0B0, 16'hC0C0, 16'hD0D0}};
    tbl[2] = '{1'b0, 3'd6, 3'd3, 0,
               '{16'hA0A0, 16'hB0B0, 16'hC0C0, 16'hD0D0}};
    tbl[3] = '{1'b0, 3'd2, 3'd3, 1,
               '{16'h1111, 16'h2222, 16'h3333, 16'h4444}};
    tbl[4] = '{1'b1, 3'd0, 3'd0, 0,
               '{16'h5A5A, 16'h0, 16'h0, 16'h0}};
    tbl[5] = '{1'b0, 3'd7, 3'd2, 0,
               '{16'hB0B0, 16'h5A5A, 16'hD0D0, 16'h0}};

    repeat (2) @(negedge clk);
    #1;
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    check("rst_rd_data", 32'(bus.rd_data), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_wr_ready", 32'(bus.wr_ready), 32'd0);
    check("rst_mem_load", 32'(mem_load), 32'd0);
    reset = 1'b0;

    // fill the whole RAM so the model starts fully known
    for (int i = 0; i < 8; i++) wbuf[i] = 16'($urandom);
    run_burst(1'b1, 3'd0, 3'd7, 0);
    for (int i = 0; i < 8; i++) ref_mem[i] = wbuf[i];
    for (int i = 0; i < 8; i++) check("fill_ram", 32'(ram[i]), 32'(ref_mem[i]));

    run_burst(1'b0, 3'd0, 3'd7, 1);
    for (int i = 0; i < 8; i++) check("full_rd", 32'(rbuf[i]), 32'(ref_mem[i]));

    foreach (tbl[k]) begin
      for (int i = 0; i < 4; i++) wbuf[i] = tbl[k].d[i];
      run_burst(tbl[k].wr, tbl[k].addr, tbl[k].len, tbl[k].p);
      for (int i = 0; i <= int'(tbl[k].len); i++) begin
        idx = (int'(tbl[k].addr) + i) % 8;
        if (tbl[k].wr) begin
          check("tbl_ram", 32'(ram[idx]), 32'(tbl[k].d[i]));
          ref_mem[idx] = tbl[k].d[i];
        end else begin
          check("tbl_rd", 32'(rbuf[i]), 32'(tbl[k].d[i]));
        end
      end
      if (tbl[k].wr && tbl[k].p == 0)
        check("busy_cycles", 32'(busy_n), 32'(int'(tbl[k].len) + 1));
    end

    // write with valid gaps
    for (int i = 0; i < 4; i++) wbuf[i] = 16'h7000 + 16'(i);
    l0 = loads;
    run_burst(1'b1, 3'd3, 3'd3, 2);
    check("gap_loads", 32'(loads - l0), 32'd4);
    check("gap_last_cycle", 32'(last_cyc), 32'd9);
    for (int i = 0; i < 4; i++) begin
      ref_mem[(3 + i) % 8] = wbuf[i];
      check("gap_ram", 32'(ram[(3 + i) % 8]), 32'(wbuf[i]));
    end

    // second command held while busy; accepted on the done cycle
    w0 = 16'h1357; w1 = 16'h2468;
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1;
    bus.cmd_addr = 3'd4; bus.cmd_len = 3'd1;
    bus.wr_valid = 1'b1; bus.wr_data = w0;
    #1 check("b2b_ready0", 32'(bus.cmd_ready), 32'd1);
    @(negedge clk);
    bus.cmd_write = 1'b0;
    #1 check("b2b_hold1", 32'(bus.cmd_ready), 32'd0);
    @(negedge clk);
    bus.wr_data = w1;
    #1 check("b2b_hold2", 32'(bus.cmd_ready), 32'd0);
    @(negedge clk);
    bus.wr_valid = 1'b0;
    #1;
    check("b2b_done", 32'(bus.done), 32'd1);
    check("b2b_ready3", 32'(bus.cmd_ready), 32'd1);
    ref_mem[4] = w0; ref_mem[5] = w1;
    @(negedge clk);
    bus.cmd_valid = 1'b0; bus.rd_ready = 1'b1;
    #1 check("b2b_rd_lat", 32'(bus.rd_valid), 32'd0);
    @(negedge clk);
    #1;
    check("b2b_rdv0", 32'(bus.rd_valid), 32'd1);
    check("b2b_rd0", 32'(bus.rd_data), 32'(w0));
    @(negedge clk);
    #1 check("b2b_rd1", 32'(bus.rd_data), 32'(w1));
    @(negedge clk);
    bus.rd_ready = 1'b0;
    #1;
    check("b2b_rd_done", 32'(bus.done), 32'd1);
    check("b2b_rd_empty", 32'(bus.rd_valid), 32'd0);

    // reset after 2 of 5 write beats
    w0 = 16'hCAFE; w1 = 16'hBEEF;
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1;
    bus.cmd_addr = 3'd1; bus.cmd_len = 3'd4;
    @(negedge clk);
    bus.cmd_valid = 1'b0; bus.wr_valid = 1'b1; bus.wr_data = w0;
    @(negedge clk);
    bus.wr_data = w1;
    @(negedge clk);
    bus.wr_valid = 1'b0; bus.wr_data = 16'hDEAD;
    reset = 1'b1;
    #1;
    check("mid_rst_ready", 32'(bus.cmd_ready), 32'd1);
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_rdv", 32'(bus.rd_valid), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    ref_mem[1] = w0; ref_mem[2] = w1;
    check("mid_rst_ram1", 32'(ram[1]), 32'(w0));
    check("mid_rst_ram2", 32'(ram[2]), 32'(w1));
    check("mid_rst_ram3", 32'(ram[3]), 32'(ref_mem[3]));
    wbuf[0] = 16'h0F0F;
    run_burst(1'b1, 3'd5, 3'd0, 0);
    ref_mem[5] = 16'h0F0F;
    check("post_rst_addr", 32'(ram[5]), 32'h0F0F);

    // reset while a read word is pending
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0;
    bus.cmd_addr = 3'd0; bus.cmd_len = 3'd7;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    #1 check("rd_pending", 32'(bus.rd_valid), 32'd1);
    reset = 1'b1;
    #1 check("rd_rst_drop", 32'(bus.rd_valid), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int t = 0; t < 30; t++) begin
      logic        wr;
      logic [2:0]  a, l;
      wr = 1'($urandom_range(0, 1));
      a  = 3'($urandom_range(0, 7));
      l  = 3'($urandom_range(0, 7));
      for (int i = 0; i < 8; i++) wbuf[i] = 16'($urandom);
      run_burst(wr, a, l, 3);
      for (int i = 0; i <= int'(l); i++) begin
        idx = (int'(a) + i) % 8;
        if (wr) ref_mem[idx] = wbuf[i];
        else check("rand_rd", 32'(rbuf[i]), 32'(ref_mem[idx]));
      end
    end
    for (int i = 0; i < 8; i++) check("final_ram", 32'(ram[i]), 32'(ref_mem[i]));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
